// File: rtl/seq_detect_ctrl.sv
// Run control for a programmable serial pattern detector.
// Optional idle timeout enabled by defining SEQ_TIMEOUT_EN.
module seq_detect_ctrl #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             timeout
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;

    logic [PAT_W-1:0] hist_sh;
    logic [FW-1:0]    fill_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    logic             run_go;

    assign hist_sh  = {hist_q[PAT_W-2:0], bit_in};
    assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign hit      = (fill_inc == FILL_MAX) && (hist_sh == pat_q);
    // a simultaneous config offer takes precedence over start
    assign run_go   = start && !cfg_valid && !abort;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [TW-1:0] tmo_inc;
    logic          tof_q, tof_d;
    assign tmo_inc = tmo_q + TW'(1);
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        tgt_d   = tgt_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
        tof_d   = tof_q;
`endif
        if (cfg_valid && state_q != S_RUN) begin
            pat_d = cfg_pattern;
            tgt_d = cfg_target;
            ovl_d = cfg_overlap;
        end
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
`ifdef SEQ_TIMEOUT_EN
                    tof_d   = 1'b0;
`endif
                end else if (run_go) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d   = '0;
                    tof_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_valid) begin
                    hist_d = hist_sh;
                    fill_d = fill_inc;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d  = '0;
`endif
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!ovl_q) fill_d = '0;
                        if (tgt_q != '0 && cnt_inc == tgt_q)
                            state_d = S_DONE;
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    tmo_d = tmo_inc;
                    if (tmo_inc == TW'(TMO_CYC)) begin
                        state_d = S_DONE;
                        tof_d   = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            tgt_q   <= '0;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            tgt_q   <= tgt_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            tof_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            tof_q <= tof_d;
        end
    end
    assign timeout = tof_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC > 0);
    assign timeout    = 1'b0;
`endif

    assign cfg_ready   = (state_q != S_RUN);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed expectations.
// Define SEQ_TIMEOUT_EN for both bench and RTL to cover the timeout.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_pattern = '0;
    logic [7:0] cfg_target = '0;
    logic       cfg_overlap = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       done;
    logic       timeout;

    int checks = 0;
    int fails  = 0;
    logic [15:0] mv;

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .TMO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target),
        .cfg_overlap(cfg_overlap),
        .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy), .match(match), .match_count(match_count),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] p, input logic [7:0] t,
                       input logic ov);
        cfg_valid = 1'b1; cfg_pattern = p;
        cfg_target = t; cfg_overlap = ov;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic stop();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // send n bits MSB first; m collects the match pulse after each bit
    task automatic send(input logic [15:0] seq, input int n,
                        output logic [15:0] m);
        m = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1; bit_in = seq[i];
            tick();
            m = {m[14:0], match};
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", match_count, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout, 0);
        rst = 1'b1;
        tick();

        // 1: overlapping, unlimited
        cfg(4'b1101, 8'd0, 1'b1);
        go();
        chk("t1_busy0", busy, 1);
        chk("t1_ready", cfg_ready, 0);
        send(16'b1101101, 7, mv);
        chk("t1_match", mv, 16'b0001001);
        chk("t1_cnt", match_count, 2);
        chk("t1_busy", busy, 1);
        chk("t1_done", done, 0);
        stop();
        chk("t1_abort_busy", busy, 0);
        chk("t1_keep_cnt", match_count, 2);

        // 2: non-overlapping
        cfg(4'b1101, 8'd0, 1'b0);
        go();
        send(16'b1101101, 7, mv);
        chk("t2_match", mv, 16'b0001000);
        chk("t2_cnt1", match_count, 1);
        send(16'b101, 3, mv);
        chk("t2_match2", mv, 16'b001);
        chk("t2_cnt2", match_count, 2);
        stop();

        // 3: target 2 ends run
        cfg(4'b1101, 8'd2, 1'b1);
        go();
        chk("t3_cnt_clr", match_count, 0);
        send(16'b1101, 4, mv);
        chk("t3_done_early", done, 0);
        send(16'b101, 3, mv);
        chk("t3_match", mv, 16'b001);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        send(16'b1101, 4, mv);
        chk("t3_ignored", mv, 0);
        chk("t3_cnt", match_count, 2);
        chk("t3_ready", cfg_ready, 1);
        go();
        chk("t3_restart", busy, 1);
        chk("t3_restart_cnt", match_count, 0);
        stop();

        // 4: abort beats a completing bit
        cfg(4'b1101, 8'd0, 1'b1);
        go();
        send(16'b110, 3, mv);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        chk("t4_match", match, 0);
        chk("t4_busy", busy, 0);
        chk("t4_cnt", match_count, 0);
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        chk("t4_cfg_start", busy, 0);
        go();
        send(16'b1101, 4, mv);
        chk("t4_flush", mv, 16'b0001);
        chk("t4_cnt1", match_count, 1);
        stop();

        // 5: fill guard, then async reset
        cfg(4'b0000, 8'd0, 1'b1);
        go();
        send(16'b000, 3, mv);
        chk("t5_guard", mv, 0);
        send(16'b0, 1, mv);
        chk("t5_match", mv, 1);
        chk("t5_cnt", match_count, 1);
        bit_valid = 1'b1; bit_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_match", match, 0);
        chk("t5_rst_cnt", match_count, 0);
        chk("t5_rst_ready", cfg_ready, 1);
        bit_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        go();
        send(16'b0000, 4, mv);
        chk("t5_rst_cfg", mv, 16'b0001);

        // 6: idle behaviour in RUN
        stop();
        go();
`ifdef SEQ_TIMEOUT_EN
        idle(15);
        chk("t6_pre", done, 0);
        tick();
        chk("t6_done", done, 1);
        chk("t6_tmo", timeout, 1);
        stop();
        chk("t6_tmo_clr", timeout, 0);
        go();
        idle(14);
        send(16'b1, 1, mv);
        idle(15);
        chk("t6_reload", done, 0);
        chk("t6_no_tmo", timeout, 0);
        tick();
        chk("t6_done2", done, 1);
`else
        idle(40);
        chk("t6_busy", busy, 1);
        chk("t6_no_tmo", timeout, 0);
        chk("t6_no_done", done, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
